// File: rtl/coin_input_conditioner_if.sv
// Coin front-end signal bundle: raw sensor lines in, conditioned coin events out.
interface coin_input_conditioner_if;
  logic [2:0] coin_raw;
  logic       coin_valid;
  logic [5:0] coin_value;
  logic       coin_err;
  logic [7:0] coin_count;

  modport master (
    output coin_raw,
    input  coin_valid,
    input  coin_value,
    input  coin_err,
    input  coin_count
  );

  modport slave (
    input  coin_raw,
    output coin_valid,
    output coin_value,
    output coin_err,
    output coin_count
  );
endinterface

// File: rtl/coin_input_conditioner.sv
// Synchronises and debounces three coin-sensor lines, turning each debounced rising
// edge into a one-cycle coin event with its cent value, an error flag and a saturating tally.
module coin_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3,
  parameter int unsigned NICKEL_VAL      = 5,
  parameter int unsigned DIME_VAL        = 10,
  parameter int unsigned QUARTER_VAL     = 25
) (
  input logic               clk,
  input logic               rst,
  coin_input_conditioner_if.slave bus
);

  typedef enum logic {SLow, SHigh} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       meta_q, sync_q;
  state_e           state_q [3];
  state_e           state_d [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic [CNT_W-1:0] cnt_d   [3];
  logic [2:0]       event_c;

  logic       valid_q, err_q;
  logic [5:0] value_q, value_d;
  logic [7:0] count_q;
  logic       single_c, multi_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= bus.coin_raw;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        state_q[i] <= SLow;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Counter tracks consecutive samples that disagree with the current state.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        SLow: begin
          if (!sync_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = SHigh;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        SHigh: begin
          if (sync_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = SLow;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      event_c[i] = (state_q[i] == SLow) && sync_q[i] && (cnt_q[i] == CntLast);
    end
  end

  assign single_c = (event_c != 3'b000) && ((event_c & (event_c - 3'b001)) == 3'b000);
  assign multi_c  = (event_c & (event_c - 3'b001)) != 3'b000;

  always_comb begin
    value_d = '0;
    unique case (event_c)
      3'b001:  value_d = 6'(NICKEL_VAL);
      3'b010:  value_d = 6'(DIME_VAL);
      3'b100:  value_d = 6'(QUARTER_VAL);
      default: value_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      value_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= single_c;
      err_q   <= multi_c;
      value_q <= value_d;
      if (single_c && (count_q != 8'hFF)) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign bus.coin_valid = valid_q;
  assign bus.coin_err   = err_q;
  assign bus.coin_value = value_q;
  assign bus.coin_count = count_q;

endmodule
